// File: rtl/idct2_mac_rnd_pipe_if.sv
// Term/result bus for the IDCT2 multiply-accumulate-round stage.
// The master drives terms and ce; the slave returns finished sums.
interface idct2_mac_rnd_pipe_if #(
    parameter int unsigned DIN0_WIDTH = 32,
    parameter int unsigned DIN1_WIDTH = 7,
    parameter int unsigned DOUT_WIDTH = 16
);
    logic                  ce;
    logic                  in_valid;
    logic                  in_last;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic [DOUT_WIDTH-1:0] dout;

    modport master (
        output ce, in_valid, in_last, din0, din1,
        input  out_valid, dout
    );

    modport slave (
        input  ce, in_valid, in_last, din0, din1,
        output out_valid, dout
    );
endinterface

// File: rtl/idct2_mac_rnd_pipe.sv
// Pipelined signed multiply with last-delimited accumulation, followed by
// round-half-up, arithmetic right shift and saturation of each finished sum.
module idct2_mac_rnd_pipe #(
    parameter int unsigned DIN0_WIDTH = 32,
    parameter int unsigned DIN1_WIDTH = 7,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned SHIFT      = 7,
    parameter int unsigned DOUT_WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset,
    idct2_mac_rnd_pipe_if.slave bus
);
    localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    // Half an output LSB; zero when no shift is applied.
    localparam logic signed [ACC_WIDTH-1:0] RND_BIAS =
        ACC_WIDTH'((64'(1) << SHIFT) >> 1);
    localparam logic signed [ACC_WIDTH-1:0] DOUT_MAX =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] DOUT_MIN = ~DOUT_MAX;

    logic signed [PROD_WIDTH-1:0] prod_c;
    logic signed [PROD_WIDTH-1:0] prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]         vld_q;
    logic [NUM_STAGE-1:0]         last_q;

    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         first_q;
    logic                         out_valid_q;
    logic [DOUT_WIDTH-1:0]        dout_q;

    logic signed [ACC_WIDTH-1:0]  acc_base_c;
    logic signed [ACC_WIDTH-1:0]  acc_sum_c;
    logic signed [ACC_WIDTH-1:0]  rnd_c;
    logic signed [ACC_WIDTH-1:0]  shift_c;
    logic [DOUT_WIDTH-1:0]        sat_c;

    assign prod_c = PROD_WIDTH'($signed(bus.din0)) * PROD_WIDTH'($signed(bus.din1));

    // Product pipeline; bubbles travel with in_valid=0 and are dropped later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
            end
            vld_q  <= '0;
            last_q <= '0;
        end else if (bus.ce) begin
            prod_q[0] <= prod_c;
            vld_q[0]  <= bus.in_valid;
            last_q[0] <= bus.in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    // Accumulate, round, shift and clip the term leaving the pipeline.
    always_comb begin
        acc_base_c = first_q ? '0 : acc_q;
        acc_sum_c  = acc_base_c + ACC_WIDTH'(prod_q[NUM_STAGE-1]);
        rnd_c      = acc_sum_c + RND_BIAS;
        shift_c    = rnd_c >>> SHIFT;
        sat_c      = DOUT_WIDTH'(shift_c);
        if (shift_c > DOUT_MAX) begin
            sat_c = DOUT_WIDTH'(DOUT_MAX);
        end else if (shift_c < DOUT_MIN) begin
            sat_c = DOUT_WIDTH'(DOUT_MIN);
        end
    end

    // Accumulator and registered result; a closing term restarts the sum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else if (bus.ce) begin
            out_valid_q <= 1'b0;
            if (vld_q[NUM_STAGE-1]) begin
                if (last_q[NUM_STAGE-1]) begin
                    dout_q      <= sat_c;
                    out_valid_q <= 1'b1;
                    first_q     <= 1'b1;
                end else begin
                    acc_q   <= acc_sum_c;
                    first_q <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
endmodule

// File: tb/tb_idct2_mac_rnd_pipe.sv
// Directed and randomized checks of the IDCT2 MAC/round stage against an
// arithmetic reference model of finished sums and their due cycles.
module tb_idct2_mac_rnd_pipe;
    localparam int unsigned DIN0_WIDTH = 32;
    localparam int unsigned DIN1_WIDTH = 7;
    localparam int unsigned NUM_STAGE  = 2;
    localparam int unsigned ACC_WIDTH  = 40;
    localparam int unsigned SHIFT      = 7;
    localparam int unsigned DOUT_WIDTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    idct2_mac_rnd_pipe_if #(
        .DIN0_WIDTH(DIN0_WIDTH), .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
    ) bus ();

    idct2_mac_rnd_pipe #(
        .DIN0_WIDTH(DIN0_WIDTH), .DIN1_WIDTH(DIN1_WIDTH), .NUM_STAGE(NUM_STAGE),
        .ACC_WIDTH(ACC_WIDTH), .SHIFT(SHIFT), .DOUT_WIDTH(DOUT_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic                  ov;
    logic [DOUT_WIDTH-1:0] od;

    // Reference model: sums are formed when terms are accepted and each
    // result becomes visible NUM_STAGE enabled edges after its last term.
    typedef struct {
        int     due;
        longint val;
    } pend_t;
    pend_t  pq[$];
    int     m_en   = 0;
    longint m_sum  = 0;
    bit     m_ov   = 1'b0;
    longint m_dout = 0;

    function automatic longint ref_out(input longint s);
        longint r, hi, lo;
        r  = (s + ((longint'(1) << SHIFT) >>> 1)) >>> SHIFT;
        hi = (longint'(1) << (DOUT_WIDTH - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // One clock: drive a term, sample after the edge, advance the model.
    task automatic step(input bit c, input bit v, input bit l, input longint a, input longint b);
        pend_t p;
        bus.ce       = c;
        bus.in_valid = v;
        bus.in_last  = l;
        bus.din0     = DIN0_WIDTH'(a);
        bus.din1     = DIN1_WIDTH'(b);
        @(posedge clk);
        #1;
        ov = bus.out_valid;
        od = bus.dout;
        if (!reset) begin
            pq.delete();
            m_sum  = 0;
            m_ov   = 1'b0;
            m_dout = 0;
        end else if (c) begin
            m_en++;
            if (v) begin
                m_sum += a * b;
                if (l) begin
                    p.due = m_en + int'(NUM_STAGE);
                    p.val = ref_out(m_sum);
                    pq.push_back(p);
                    m_sum = 0;
                end
            end
            m_ov = 1'b0;
            if (pq.size() > 0 && pq[0].due == m_en) begin
                m_ov   = 1'b1;
                m_dout = pq[0].val;
                void'(pq.pop_front());
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(bit'(i), 1'b1, 1'b1, 5, 5);
            n_checks++;
            if (ov !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out_valid step %0d: got %b want 0", i, ov);
            end
            n_checks++;
            if (od !== '0) begin
                n_fail++;
                $display("FAIL reset_dout step %0d: got %0d want 0", i, $signed(od));
            end
        end
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_single(input longint a, input longint b, input longint want, input string name);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1'b1, 1'b1, 1'b1, a, b);
            else        step(1'b1, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (ov !== (i == int'(NUM_STAGE))) begin
                n_fail++;
                $display("FAIL %s_valid step %0d: got %b want %b", name, i, ov, i == int'(NUM_STAGE));
            end
            if (i == int'(NUM_STAGE)) begin
                n_checks++;
                if (od !== DOUT_WIDTH'(want)) begin
                    n_fail++;
                    $display("FAIL %s_dout: got %0d want %0d", name, $signed(od), want);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 9; i++) begin
            if (i < 4)       step(1'b1, 1'b1, i == 3, 1000 * (i + 1), 32);
            else if (i == 4) step(1'b1, 1'b1, 1'b1, 128, 1);
            else             step(1'b1, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (ov !== (i == 5 || i == 6)) begin
                n_fail++;
                $display("FAIL b2b_valid step %0d: got %b want %b", i, ov, i == 5 || i == 6);
            end
            if (i == 5 || i == 6) begin
                n_checks++;
                if (od !== DOUT_WIDTH'(i == 5 ? 2500 : 1)) begin
                    n_fail++;
                    $display("FAIL b2b_dout step %0d: got %0d want %0d", i, $signed(od), i == 5 ? 2500 : 1);
                end
            end
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      step(1'b1, 1'b1, 1'b1, longint'(1) << 24, 63);
            else if (i == 1) step(1'b1, 1'b1, 1'b1, -(longint'(1) << 24), 63);
            else             step(1'b1, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (ov !== (i == 2 || i == 3)) begin
                n_fail++;
                $display("FAIL sat_valid step %0d: got %b want %b", i, ov, i == 2 || i == 3);
            end
            if (i == 2 || i == 3) begin
                n_checks++;
                if (od !== DOUT_WIDTH'(i == 2 ? 32767 : -32768)) begin
                    n_fail++;
                    $display("FAIL sat_dout step %0d: got %0d want %0d", i, $signed(od), i == 2 ? 32767 : -32768);
                end
            end
        end
    endtask

    task automatic test_ce_stall;
        int t;
        for (int i = 0; i < 11; i++) begin
            if (i >= 2 && i <= 4) begin
                step(1'b0, 1'b1, 1'b1, longint'($urandom_range(0, 100000)), 17);
            end else if (i < 7) begin
                t = (i < 2) ? i : i - 3;
                step(1'b1, 1'b1, t == 3, 1000 * (t + 1), 32);
            end else begin
                step(1'b1, 1'b0, 1'b0, 0, 0);
            end
            n_checks++;
            if (ov !== (i == 8)) begin
                n_fail++;
                $display("FAIL stall_valid step %0d: got %b want %b", i, ov, i == 8);
            end
            if (i == 8) begin
                n_checks++;
                if (od !== DOUT_WIDTH'(2500)) begin
                    n_fail++;
                    $display("FAIL stall_dout: got %0d want 2500", $signed(od));
                end
            end
        end
    endtask

    task automatic test_reset_mid_sum;
        for (int i = 0; i < 8; i++) begin
            reset = (i == 2) ? 1'b0 : 1'b1;
            if (i < 2)       step(1'b1, 1'b1, 1'b0, 1000, 32);
            else if (i == 3) step(1'b1, 1'b1, 1'b1, 128, 1);
            else             step(1'b1, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (ov !== (i == 5)) begin
                n_fail++;
                $display("FAIL rstmid_valid step %0d: got %b want %b", i, ov, i == 5);
            end
            if (i == 2 || i == 5) begin
                n_checks++;
                if (od !== DOUT_WIDTH'(i == 2 ? 0 : 1)) begin
                    n_fail++;
                    $display("FAIL rstmid_dout step %0d: got %0d want %0d", i, $signed(od), i == 2 ? 0 : 1);
                end
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_random;
        bit     c, v, l;
        longint a, b;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            c = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 4) != 0);
            l = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) a = longint'($urandom_range(0, 1 << 27)) - (longint'(1) << 26);
            else                           a = longint'($urandom_range(0, 8191)) - 4096;
            b = longint'($urandom_range(0, 127)) - 64;
            step(c, v, l, a, b);
            n_checks++;
            if (ov !== m_ov) begin
                n_fail++;
                $display("FAIL rand_valid step %0d: got %b want %b", i, ov, m_ov);
            end
            n_checks++;
            if (od !== DOUT_WIDTH'(m_dout)) begin
                n_fail++;
                $display("FAIL rand_dout step %0d: got %0d want %0d", i, $signed(od), m_dout);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        bus.ce       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;
        test_reset();
        test_single(100, 32, 25, "single");
        test_single(-100, 32, -25, "neg_round");
        test_back_to_back();
        test_saturation();
        test_ce_stall();
        test_reset_mid_sum();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/idct2_mac_rnd_pipe.md
Name: idct2_mac_rnd_pipe

Overview:
- Parametrised successor to the IDCT2 fixed-latency signed multiplier.
- Adds a configurable-depth product pipeline with valid tracking and multi-term accumulation delimited by a last flag.
- Produces a rounded, shifted and saturated output for each accumulated sum.
- Sits between the coefficient ROM/transpose buffer and the IDCT2 output stage; computes one (sum of c*x + round) >> SHIFT per butterfly output.

Parameters:
- DIN0_WIDTH, 32: signed sample operand width.
- DIN1_WIDTH, 7: signed coefficient operand width.
- NUM_STAGE, 2: product pipeline registers, legal range 1 to 4.
- ACC_WIDTH, 40: signed accumulator width; must be at least DIN0_WIDTH+DIN1_WIDTH.
- SHIFT, 7: arithmetic right shift applied after rounding; 0 means no rounding and no shift.
- DOUT_WIDTH, 16: signed saturated output width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low (reset=0 clears the block at the clock edge).
- ce  in  1  global clock enable; ce=0 freezes every register.
- in_valid  in  1  din0/din1 carry one term this cycle.
- in_last  in  1  this term closes the current sum; meaningful only when in_valid=1.
- din0  in  DIN0_WIDTH  signed sample.
- din1  in  DIN1_WIDTH  signed coefficient.
- out_valid  out  1  dout holds a finished sum.
- dout  out  DOUT_WIDTH  signed rounded/saturated result.

Behaviour:
- Reset (reset=0 at posedge, ce ignored):
  - All pipeline valid bits cleared; accumulator cleared; first-term flag set.
  - dout=0, out_valid=0.
  - A partially accumulated sum is discarded with no output.
- ce=0: all registers hold, including out_valid and dout. Inputs are ignored. Consumers qualify out_valid with ce.
- Product pipeline:
  - When ce=1, p = $signed(din0)*$signed(din1), full width DIN0_WIDTH+DIN1_WIDTH, no truncation.
  - p is captured into stage 1 together with in_valid and in_last, then shifted through NUM_STAGE registers.
  - A term with in_valid=0 enters as a bubble; bubbles never touch the accumulator.
- Accumulate stage (ce=1, valid term leaving stage NUM_STAGE):
  - acc_new = (first ? 0 : acc) + sign_extend(p) to ACC_WIDTH.
  - Overflow wraps two's complement; sizing is the integrator's responsibility.
  - If last=0: acc <= acc_new, first <= 0.
  - If last=1: r = (acc_new + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT. dout <= clip(r) to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]. out_valid <= 1, first <= 1.
  - Otherwise (no valid term leaving, ce=1): out_valid <= 0, dout holds its last value.
- Latency: an in_last term accepted at ce-enabled cycle T gives out_valid=1 at ce-enabled cycle T+NUM_STAGE+1.
- Throughput: one term per ce-enabled cycle. Back-to-back sums are allowed; a sum's first term may directly follow the previous sum's last term with no bubble.
- Single-term sums (in_valid=1, in_last=1 with first set) are legal.
- Rounding is round-half-up in two's complement: -24.5 rounds to -25 via floor after the bias is added.

Test Plan:
- Single term (defaults): din0=100, din1=32, last=1 -> 3200+64=3264>>7 -> dout=25, out_valid high exactly 3 cycles after input, for 1 cycle.
- Negative rounding: din0=-100, din1=32, last=1 -> -3136>>>7 -> dout=-25.
- Four-term sum: din0=1000,2000,3000,4000, din1=32 each, last on 4th, back-to-back -> single out_valid pulse, dout=2500. Immediately followed by single term din0=128, din1=1 -> next pulse, dout=1.
- Saturation: din0=2^24, din1=63 -> dout=32767. din0=-(2^24), din1=63 -> dout=-32768.
- ce stall: repeat the four-term case with ce=0 for 3 cycles after the second term -> dout=2500, out_valid delayed exactly 3 cycles. Inputs driven while ce=0 have no effect.
- Reset mid-sum: two terms (din0=1000, din1=32) accepted, reset=0 for 1 cycle, then din0=128, din1=1, last=1 -> dout=1. No out_valid is produced for the aborted sum; dout=0 and out_valid=0 during reset.
